// File: rtl/instr_encoder.sv
// RV32I instruction word encoder: one registered output slot, addresses advance by 4 per emitted word,
// and illegal requests are flagged on err_pulse/err_sticky instead of being emitted.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [5:0]  in_alucode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic        err_sticky,
  output logic [15:0] instr_count
);
  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_OPIMM = 7'b0010011, OPC_AUIPC = 7'b0010111,
                         OPC_STORE = 7'b0100011, OPC_OP = 7'b0110011, OPC_LUI = 7'b0110111,
                         OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111;

  localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_SLL = 6'd2, ALU_SLT = 6'd3,
                         ALU_SLTU = 6'd4, ALU_XOR = 6'd5, ALU_SRL = 6'd6, ALU_SRA = 6'd7,
                         ALU_OR = 6'd8, ALU_AND = 6'd9,
                         ALU_LB = 6'd10, ALU_LH = 6'd11, ALU_LW = 6'd12, ALU_LBU = 6'd13, ALU_LHU = 6'd14,
                         ALU_SB = 6'd15, ALU_SH = 6'd16, ALU_SW = 6'd17,
                         ALU_BEQ = 6'd18, ALU_BNE = 6'd19, ALU_BLT = 6'd20, ALU_BGE = 6'd21,
                         ALU_BLTU = 6'd22, ALU_BGEU = 6'd23;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        err_pulse_q, err_pulse_d;
  logic        err_sticky_q, err_sticky_d;
  logic [15:0] count_q, count_d;

  logic signed [31:0] imm_s;
  logic        i_ok, sh_ok, b_ok, j_ok, u_ok;
  logic [2:0]  f3;
  logic        alu_arith, alu_ld, alu_st, alu_br, alu_shift;
  logic        enc_ok;
  logic [31:0] enc_word;
  logic        accept, emit;

  assign imm_s = in_imm;
  assign i_ok  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign sh_ok = (in_imm[31:5] == 27'd0);
  assign b_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
  assign j_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
  assign u_ok  = (in_imm[11:0] == 12'd0);

  // funct3 and the opcode class each ALU code belongs to
  always_comb begin
    f3 = 3'b000;
    alu_arith = 1'b0;
    alu_ld    = 1'b0;
    alu_st    = 1'b0;
    alu_br    = 1'b0;
    case (in_alucode)
      ALU_ADD, ALU_SUB: alu_arith = 1'b1;
      ALU_SLL:          begin alu_arith = 1'b1; f3 = 3'b001; end
      ALU_SLT:          begin alu_arith = 1'b1; f3 = 3'b010; end
      ALU_SLTU:         begin alu_arith = 1'b1; f3 = 3'b011; end
      ALU_XOR:          begin alu_arith = 1'b1; f3 = 3'b100; end
      ALU_SRL, ALU_SRA: begin alu_arith = 1'b1; f3 = 3'b101; end
      ALU_OR:           begin alu_arith = 1'b1; f3 = 3'b110; end
      ALU_AND:          begin alu_arith = 1'b1; f3 = 3'b111; end
      ALU_LB:           alu_ld = 1'b1;
      ALU_LH:           begin alu_ld = 1'b1; f3 = 3'b001; end
      ALU_LW:           begin alu_ld = 1'b1; f3 = 3'b010; end
      ALU_LBU:          begin alu_ld = 1'b1; f3 = 3'b100; end
      ALU_LHU:          begin alu_ld = 1'b1; f3 = 3'b101; end
      ALU_SB:           alu_st = 1'b1;
      ALU_SH:           begin alu_st = 1'b1; f3 = 3'b001; end
      ALU_SW:           begin alu_st = 1'b1; f3 = 3'b010; end
      ALU_BEQ:          alu_br = 1'b1;
      ALU_BNE:          begin alu_br = 1'b1; f3 = 3'b001; end
      ALU_BLT:          begin alu_br = 1'b1; f3 = 3'b100; end
      ALU_BGE:          begin alu_br = 1'b1; f3 = 3'b101; end
      ALU_BLTU:         begin alu_br = 1'b1; f3 = 3'b110; end
      ALU_BGEU:         begin alu_br = 1'b1; f3 = 3'b111; end
      default:          f3 = 3'b000;
    endcase
  end

  assign alu_shift = (in_alucode == ALU_SLL) || (in_alucode == ALU_SRL) || (in_alucode == ALU_SRA);

  // JAL, JALR, LUI and AUIPC carry no ALU selector, so in_alucode is not checked for them
  always_comb begin
    enc_ok   = 1'b0;
    enc_word = 32'd0;
    case (in_opcode)
      OPC_OP: begin
        enc_ok   = alu_arith;
        enc_word = {((in_alucode == ALU_SUB) || (in_alucode == ALU_SRA)) ? 7'b0100000 : 7'b0000000,
                    in_rs2, in_rs1, f3, in_rd, in_opcode};
      end
      OPC_OPIMM: begin
        if (alu_shift) begin
          enc_ok   = sh_ok;
          enc_word = {(in_alucode == ALU_SRA) ? 7'b0100000 : 7'b0000000,
                      in_imm[4:0], in_rs1, f3, in_rd, in_opcode};
        end else begin
          enc_ok   = alu_arith && (in_alucode != ALU_SUB) && i_ok;
          enc_word = {in_imm[11:0], in_rs1, f3, in_rd, in_opcode};
        end
      end
      OPC_LOAD: begin
        enc_ok   = alu_ld && i_ok;
        enc_word = {in_imm[11:0], in_rs1, f3, in_rd, in_opcode};
      end
      OPC_JALR: begin
        enc_ok   = i_ok;
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode};
      end
      OPC_STORE: begin
        enc_ok   = alu_st && i_ok;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], in_opcode};
      end
      OPC_BRANCH: begin
        enc_ok   = alu_br && b_ok;
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], in_opcode};
      end
      OPC_JAL: begin
        enc_ok   = j_ok;
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      OPC_LUI, OPC_AUIPC: begin
        enc_ok   = u_ok;
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      end
      default: enc_ok = 1'b0;
    endcase
  end

  assign in_ready = !start && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    count_d      = count_q;
    if (start) begin
      out_valid_d  = 1'b0;
      out_addr_d   = base_addr & ~32'h3;
      err_sticky_d = 1'b0;
      count_d      = 16'd0;
    end else begin
      if (emit) begin
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q + 32'd4;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
      if (accept) begin
        if (enc_ok) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_word;
        end else begin
          err_pulse_d  = 1'b1;
          err_sticky_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'd0;
      out_addr_q   <= 32'd0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      count_q      <= 16'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      count_q      <= count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = out_addr_q;
  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign instr_count = count_q;
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that loads base_addr and clears the counters.
REQ-004 SHALL have port base_addr, input, 32, write address of the first emitted word; bits [1:0] are ignored and treated as 0.
REQ-005 SHALL have port in_valid / in_ready, input / output, 1 each, request handshake.
REQ-006 SHALL have port in_opcode, input, 7, RV32I major opcode: OPIMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD or STORE per define.vh.
REQ-007 SHALL have port in_alucode, input, 6, ALU_* code per define.vh.
REQ-008 SHALL have ports in_rd, in_rs1 and in_rs2, input, 5 each, register numbers.
REQ-009 SHALL have port in_imm, input, 32, final sign-extended immediate; for LUI and AUIPC this is the upper-aligned value.
REQ-010 SHALL have port out_valid / out_ready, output / input, 1 each, emit handshake.
REQ-011 SHALL have ports out_instr and out_addr, output, 32 each, encoded word and its instruction-memory address.
REQ-012 SHALL have port err_pulse, output, 1, high for one cycle per rejected request.
REQ-013 SHALL have port err_sticky, output, 1, set on any rejection and held until start or reset.
REQ-014 SHALL have port instr_count, output, 16, count of emitted words; saturates at 0xFFFF.

Function
REQ-015 SHALL drive in_ready = !start && (!out_valid || out_ready); a request is accepted on in_valid && in_ready.
REQ-016 SHALL, for an accepted valid request, present out_valid=1 with out_instr in the next cycle (latency 1).
REQ-017 SHALL hold out_instr and out_addr stable while out_valid && !out_ready.
REQ-018 SHALL allow accept and emit in the same cycle, giving full throughput of one word per cycle.
REQ-019 SHALL encode OP words as funct7|rs2|rs1|funct3|rd|opcode; ALU_SUB and ALU_SRA use funct7=0100000, all other codes use 0000000.
REQ-020 SHALL encode OPIMM words in I-format; ALU_SLL, ALU_SRL and ALU_SRA place shamt=imm[4:0] in [24:20], and ALU_SRA sets [31:25]=0100000.
REQ-021 SHALL encode LOAD (ALU_LB/LH/LW/LBU/LHU -> funct3 000/001/010/100/101) and JALR (funct3 000) in I-format.
REQ-022 SHALL encode STORE (ALU_SB/SH/SW -> 000/001/010) in S-format: imm[11:5] to [31:25], imm[4:0] to [11:7].
REQ-023 SHALL encode BRANCH (ALU_BEQ/BNE/BLT/BGE/BLTU/BGEU -> 000/001/100/101/110/111) in B-format: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
REQ-024 SHALL encode JAL in J-format: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
REQ-025 SHALL encode LUI and AUIPC as in_imm[31:12]|rd|opcode.
REQ-026 SHALL ignore in_rs1 and in_rs2 where the format has no such field, and ignore in_rd for S- and B-format.
REQ-027 SHALL reject a request on any of these conditions: unknown opcode; alucode illegal for the opcode; I/S imm outside -2048..2047; shift imm outside 0..31; B imm outside -4096..4094 or odd; J imm outside +/-1 MiB or odd; LUI/AUIPC imm[11:0] != 0.
REQ-028 SHALL, on a rejected request, still accept it (in_ready rules unchanged), emit no word, leave out_addr unadvanced, assert err_pulse in the next cycle, and set err_sticky.
REQ-029 SHALL, on each emit handshake, advance out_addr by 4 (wrapping 0xFFFFFFFC -> 0x00000000) and increment instr_count unless it is 0xFFFF.
REQ-030 SHALL, on start, load out_addr=base_addr&~3, clear instr_count, err_sticky and out_valid, and drop any pending word; in_ready=0 during that cycle.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force out_valid=0, out_instr=0, out_addr=0, err_pulse=0, err_sticky=0 and instr_count=0.
REQ-032 SHALL discard a word pending at reset assertion; the first accept after release is emitted at out_addr=0 unless start occurs first.

Verification
REQ-033 SHALL verify: start base=0x100; OPIMM ADD rd=1 rs1=0 imm=5, then OP SUB rd=3 rs1=1 rs2=2 -> 0x00500093 @0x100, 0x402081B3 @0x104, instr_count=2.
REQ-034 SHALL verify: BRANCH BEQ rs1=1 rs2=2 imm=8, STORE SW rs1=1 rs2=2 imm=4, LUI rd=5 imm=0x12345000 -> 0x00208463, 0x0020A223, 0x123452B7.
REQ-035 SHALL verify: OPIMM SLL rd=1 rs1=1 imm=3 -> 0x00309093; OPIMM SLL imm=32 -> err_pulse, err_sticky=1, no word, out_addr unchanged.
REQ-036 SHALL verify: out_ready=0 for 3 cycles with 2 requests offered -> the first word is held stable, in_ready=0 while the first word is held, both words are emitted in order after release.
REQ-037 SHALL verify: base=0xFFFFFFFC with 2 valid requests -> addresses 0xFFFFFFFC, then 0x00000000.
REQ-038 SHALL verify: rst_n pulsed low with a word pending -> out_valid=0 immediately, all outputs 0, normal encoding resumes at out_addr=0.
